// File: rtl/pff_param_flop.sv
// Single-bit flop whose storage mode (D or T) is selected at elaboration time.
// Only one state bit is stored. q and qbar are both derived from that bit, so the two
// outputs can never disagree, including during reset.
module pff_param_flop #(
  // "DFF" = plain D flop, "TFF" = toggle flop with d acting as the toggle enable
  parameter string FF_TYPE = "DFF"
) (
  input  logic d,
  input  logic rstn,
  input  logic clk,
  output logic q,
  output logic qbar
);

  logic state_q;
  logic state_d;

  // Next-state selection is resolved at elaboration. An unknown mode stops the build.
  generate
    if (FF_TYPE == "DFF") begin : g_dff
      // D mode: capture d on every rising edge
      always_comb begin
        state_d = d;
      end
    end else if (FF_TYPE == "TFF") begin : g_tff
      // T mode: d=1 toggles the state, d=0 holds it
      always_comb begin
        state_d = state_q ^ d;
      end
    end else begin : g_bad
      $error("pff_param_flop: unsupported FF_TYPE \"%s\" (use \"DFF\" or \"TFF\")", FF_TYPE);
      // Keeps state_d driven so the only diagnostic is the one above
      always_comb begin
        state_d = state_q;
      end
    end
  endgenerate

  // State register. The asynchronous reset wins over any coincident clock edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= 1'b0;
    end else begin
      state_q <= state_d;
    end
  end

  assign q    = state_q;
  assign qbar = ~state_q;

endmodule

// File: tb/tb_pff_param_flop.sv
// Directed bench for pff_param_flop. It covers both the D and the T configuration.
// Inputs change on the falling edge. Outputs are sampled 1 time unit after the rising edge.
module tb_pff_param_flop;

  logic clk;
  logic rstn;
  logic d_dff;
  logic d_tff;
  logic q_dff;
  logic qbar_dff;
  logic q_tff;
  logic qbar_tff;

  int total;
  int bad;

  pff_param_flop #(.FF_TYPE("DFF")) u_dff (
    .d    (d_dff),
    .rstn (rstn),
    .clk  (clk),
    .q    (q_dff),
    .qbar (qbar_dff)
  );

  pff_param_flop #(.FF_TYPE("TFF")) u_tff (
    .d    (d_tff),
    .rstn (rstn),
    .clk  (clk),
    .q    (q_tff),
    .qbar (qbar_tff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Checks q against the expected value and qbar against its complement
  task automatic check_pair(input string tag, input logic q_obs, input logic qb_obs,
                            input logic exp);
    check({tag, ".q"}, q_obs, exp);
    check({tag, ".qbar"}, qb_obs, ~exp);
  endtask

  initial begin
    logic [3:0] pat;
    logic [2:0] tog;
    logic       rnd;
    total = 0;
    bad   = 0;
    pat   = 4'b1001;
    tog   = 3'b101;

    // Reset takes effect immediately, before any clock edge
    rstn  = 1'b0;
    d_dff = 1'b1;
    d_tff = 1'b1;
    #1;
    check_pair("rst_async_dff", q_dff, qbar_dff, 1'b0);
    check_pair("rst_async_tff", q_tff, qbar_tff, 1'b0);

    // Clock edges are ignored while reset is held, even with d=1
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_pair("rst_hold_dff", q_dff, qbar_dff, 1'b0);
      check_pair("rst_hold_tff", q_tff, qbar_tff, 1'b0);
    end

    // Release at a negedge. The very next posedge performs a normal update.
    @(negedge clk);
    rstn  = 1'b1;
    d_tff = 1'b0;
    @(posedge clk); #1;
    check_pair("release_dff", q_dff, qbar_dff, 1'b1);
    check_pair("release_tff_hold", q_tff, qbar_tff, 1'b0);

    // D pattern 1,0,0,1. q follows one edge later and must not move between edges.
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk);
      d_dff = pat[i];
      #1;
      check("dff_pat_pre_edge", q_dff, (i == 3) ? 1'b1 : pat[i+1]);
      @(posedge clk); #1;
      check_pair("dff_pat", q_dff, qbar_dff, pat[i]);
    end

    // Random d against a one-edge-delay reference
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rnd   = 1'($urandom_range(0, 1));
      d_dff = rnd;
      @(posedge clk); #1;
      check_pair("dff_rand", q_dff, qbar_dff, rnd);
    end

    // TFF: reset, then d=1 for 3 edges -> 1,0,1, then d=0 for 2 edges -> holds 1
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_pair("tff_rst", q_tff, qbar_tff, 1'b0);
    @(negedge clk);
    rstn  = 1'b1;
    d_tff = 1'b1;
    for (int i = 2; i >= 0; i--) begin
      @(posedge clk); #1;
      check_pair("tff_toggle", q_tff, qbar_tff, tog[i]);
    end
    @(negedge clk);
    d_tff = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check_pair("tff_hold", q_tff, qbar_tff, 1'b1);
    end

    // Async reset mid-run. Both flops hold 1, then rstn drops between edges.
    @(negedge clk);
    d_dff = 1'b1;
    @(posedge clk); #1;
    check("mid_pre_dff", q_dff, 1'b1);
    check("mid_pre_tff", q_tff, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check_pair("mid_rst_dff", q_dff, qbar_dff, 1'b0);
    check_pair("mid_rst_tff", q_tff, qbar_tff, 1'b0);

    // X on d has no effect while reset is held
    d_dff = 1'bx;
    d_tff = 1'bx;
    @(posedge clk); #1;
    check_pair("x_in_rst_dff", q_dff, qbar_dff, 1'b0);
    check_pair("x_in_rst_tff", q_tff, qbar_tff, 1'b0);

    // After release, X reaches q only at the clock edge
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("x_pre_edge_dff", q_dff, 1'b0);
    @(posedge clk); #1;
    check("x_edge_dff", q_dff, 1'bx);
    @(negedge clk);
    d_dff = 1'b0;
    d_tff = 1'b0;
    @(posedge clk); #1;
    check_pair("x_recover_dff", q_dff, qbar_dff, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
